// File: rtl/fps_map_ext.sv
// Front-panel output mapper: per-channel source select, invert and pulse stretch,
// with double-buffered configuration that switches every channel on one apply edge.
module fps_map_ext #(
  parameter int N_OUT   = 6,
  parameter int N_PULSE = 14,
  parameter int N_DBUS  = 8,
  parameter int SEL_W   = 6,
  parameter int LEN_W   = 8,
  localparam int CH_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_PULSE-1:0] pulses_i,
  input  logic [N_DBUS-1:0]  databus_i,
  input  logic               cfg_we_i,
  input  logic [CH_W-1:0]    cfg_ch_i,
  input  logic [SEL_W-1:0]   cfg_sel_i,
  input  logic               cfg_inv_i,
  input  logic [LEN_W-1:0]   cfg_len_i,
  input  logic               cfg_apply_i,
  output logic               cfg_pending_o,
  output logic [N_OUT-1:0]   front_out_o
);

  localparam int PULSE_BASE = 'h0B;
  localparam int DBUS_BASE  = 'h20;
  localparam logic [SEL_W-1:0] SEL_ONE = SEL_W'('h3E);

  logic cfg_accept;
  logic pending_q, pending_d;

  assign cfg_accept = cfg_we_i && (32'(cfg_ch_i) < N_OUT);

  // A same-edge apply absorbs the write, so pending only survives without apply.
  always_comb begin
    pending_d = pending_q;
    if (cfg_apply_i)     pending_d = 1'b0;
    else if (cfg_accept) pending_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= 1'b0;
    else        pending_q <= pending_d;
  end

  assign cfg_pending_o = pending_q;

  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_ch
    logic             we_hit;
    logic [SEL_W-1:0] sel_sh_q, sel_sh_d, sel_q;
    logic             inv_sh_q, inv_sh_d, inv_q;
    logic [LEN_W-1:0] len_sh_q, len_sh_d, len_q;
    logic             src;
    logic             s1_q, s1p_q, front_q, rise;
    logic [LEN_W-1:0] cnt_q, cnt_d;

    assign we_hit = cfg_we_i && (cfg_ch_i == CH_W'(gi));

    always_comb begin
      sel_sh_d = sel_sh_q;
      inv_sh_d = inv_sh_q;
      len_sh_d = len_sh_q;
      if (we_hit) begin
        sel_sh_d = cfg_sel_i;
        inv_sh_d = cfg_inv_i;
        len_sh_d = cfg_len_i;
      end
    end

    // Unlisted codes (gaps, 0x3F, beyond the bus widths) decode to constant 0.
    always_comb begin
      src = 1'b0;
      for (int k = 0; k < N_PULSE; k++)
        if (sel_q == SEL_W'(PULSE_BASE + k)) src = pulses_i[k];
      for (int k = 0; k < N_DBUS; k++)
        if (sel_q == SEL_W'(DBUS_BASE + k)) src = databus_i[k];
      if (sel_q == SEL_ONE) src = 1'b1;
    end

    assign rise = s1_q & ~s1p_q;

    always_comb begin
      cnt_d = cnt_q;
      if (rise && (len_q != '0)) cnt_d = len_q - LEN_W'(1);
      else if (cnt_q != '0)      cnt_d = cnt_q - LEN_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sel_sh_q <= '0;
        inv_sh_q <= 1'b0;
        len_sh_q <= '0;
        sel_q    <= '0;
        inv_q    <= 1'b0;
        len_q    <= '0;
        s1_q     <= 1'b0;
        s1p_q    <= 1'b0;
        cnt_q    <= '0;
        front_q  <= 1'b0;
      end else begin
        sel_sh_q <= sel_sh_d;
        inv_sh_q <= inv_sh_d;
        len_sh_q <= len_sh_d;
        s1_q     <= src;
        front_q  <= (s1_q | (cnt_q != '0)) ^ inv_q;
        // Apply restarts edge detection so a source already high yields one rise.
        if (cfg_apply_i) begin
          sel_q <= sel_sh_d;
          inv_q <= inv_sh_d;
          len_q <= len_sh_d;
          s1p_q <= 1'b0;
          cnt_q <= '0;
        end else begin
          s1p_q <= s1_q;
          cnt_q <= cnt_d;
        end
      end
    end

    assign front_out_o[gi] = front_q;
  end

endmodule

// File: tb/tb_fps_map_ext.sv
// Directed bench for fps_map_ext: mapping, stretch, invert, shadow/apply and reset.
module tb_fps_map_ext;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] pulses;
  logic [7:0]  databus;
  logic        cfg_we;
  logic [2:0]  cfg_ch;
  logic [5:0]  cfg_sel;
  logic        cfg_inv;
  logic [7:0]  cfg_len;
  logic        cfg_apply;
  logic        cfg_pending;
  logic [5:0]  front_out;

  int total = 0;
  int bad   = 0;

  fps_map_ext dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pulses_i     (pulses),
    .databus_i    (databus),
    .cfg_we_i     (cfg_we),
    .cfg_ch_i     (cfg_ch),
    .cfg_sel_i    (cfg_sel),
    .cfg_inv_i    (cfg_inv),
    .cfg_len_i    (cfg_len),
    .cfg_apply_i  (cfg_apply),
    .cfg_pending_o(cfg_pending),
    .front_out_o  (front_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
    $display("check %s obs=%0h exp=%0h", tag, obs, exp);
  endtask

  task automatic cfg_write(input logic [2:0] ch, input logic [5:0] sel, input logic inv,
                           input logic [7:0] len, input logic apply);
    cfg_we = 1'b1; cfg_ch = ch; cfg_sel = sel; cfg_inv = inv; cfg_len = len;
    cfg_apply = apply;
    tick();
    cfg_we = 1'b0; cfg_apply = 1'b0;
  endtask

  task automatic apply();
    cfg_apply = 1'b1;
    tick();
    cfg_apply = 1'b0;
  endtask

  // Cycle c drives pin[c] on the chosen input bit, then checks channel ch against exp[c]
  // and all other channels against the constant oth.
  task automatic seq(input string tag, input int ncyc, input bit use_dbus, input int pbit,
                     input logic [31:0] pin, input int ch, input logic [31:0] exp,
                     input logic [5:0] oth);
    logic [5:0] mask;
    mask = 6'(1 << ch);
    for (int c = 0; c < ncyc; c++) begin
      if (use_dbus) databus[pbit] = pin[c];
      else          pulses[pbit]  = pin[c];
      tick();
      check($sformatf("%s_c%0d", tag, c), 32'(front_out[ch]), 32'(exp[c]));
      check($sformatf("%s_oth_c%0d", tag, c), 32'(front_out & ~mask), 32'(oth));
    end
    pulses  = '0;
    databus = '0;
  endtask

  initial begin
    rst_n = 1'b0; pulses = '1; databus = '1;
    cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_inv = 1'b0; cfg_len = '0;
    cfg_apply = 1'b0;

    // Reset with all sources high
    tick(); tick(); tick();
    check("rst_front", 32'(front_out), 32'h0);
    check("rst_pending", 32'(cfg_pending), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_front", 32'(front_out), 32'h0);
    end
    pulses = '0; databus = '0;
    tick();

    // Mapping ch0 <- pulses[0], ch5 <- databus[7]
    cfg_write(3'd0, 6'h0B, 1'b0, 8'd0, 1'b0);
    cfg_write(3'd5, 6'h27, 1'b0, 8'd0, 1'b0);
    check("map_pending_set", 32'(cfg_pending), 32'h1);
    apply();
    check("map_pending_clr", 32'(cfg_pending), 32'h0);
    seq("map_ch0", 4, 1'b0, 0, 32'h1, 0, 32'h2, 6'h00);
    seq("map_ch5", 4, 1'b1, 7, 32'h1, 5, 32'h2, 6'h00);

    // Stretch on ch1, len=5
    cfg_write(3'd1, 6'h0C, 1'b0, 8'd5, 1'b1);
    seq("str_short", 8, 1'b0, 1, 32'h1, 1, 32'h3E, 6'h00);
    seq("str_long", 12, 1'b0, 1, 32'hFF, 1, 32'h1FE, 6'h00);
    seq("str_retrig", 12, 1'b0, 1, 32'h9, 1, 32'h1FE, 6'h00);

    // Invert on an unmapped code, and the constant-one code
    cfg_write(3'd2, 6'h30, 1'b1, 8'd0, 1'b0);
    apply();
    tick();
    check("inv_unmapped", 32'(front_out), 32'h04);
    cfg_write(3'd3, 6'h3E, 1'b0, 8'd0, 1'b0);
    apply();
    tick(); tick();
    check("const_one", 32'(front_out), 32'h0C);
    seq("const_hold", 4, 1'b0, 0, 32'h1, 0, 32'h2, 6'h0C);

    // Shadow write without apply leaves ch0 on pulses[0]
    cfg_write(3'd0, 6'h0D, 1'b0, 8'd0, 1'b0);
    check("shadow_pending", 32'(cfg_pending), 32'h1);
    seq("shadow_old_src", 4, 1'b0, 0, 32'h1, 0, 32'h2, 6'h0C);
    seq("shadow_new_idle", 4, 1'b0, 2, 32'h1, 0, 32'h0, 6'h0C);
    check("shadow_pending_hold", 32'(cfg_pending), 32'h1);
    cfg_write(3'd4, 6'h3E, 1'b0, 8'd0, 1'b1);
    check("we_apply_pending", 32'(cfg_pending), 32'h0);
    tick(); tick();
    check("we_apply_ch4", 32'(front_out), 32'h1C);
    seq("applied_new_src", 4, 1'b0, 2, 32'h1, 0, 32'h2, 6'h1C);

    // Out-of-range channel is ignored entirely
    cfg_write(3'd7, 6'h0B, 1'b1, 8'd9, 1'b0);
    check("ch7_pending", 32'(cfg_pending), 32'h0);
    apply();
    tick();
    seq("ch7_nochange", 4, 1'b0, 2, 32'h1, 0, 32'h2, 6'h1C);

    // Apply mid-stretch clears the counter
    pulses[1] = 1'b1;
    tick();
    pulses[1] = 1'b0;
    tick(); tick();
    check("midstr_high", 32'(front_out[1]), 32'h1);
    cfg_write(3'd1, 6'h3F, 1'b0, 8'd5, 1'b1);
    check("midstr_apply_edge", 32'(front_out[1]), 32'h1);
    tick();
    check("midstr_cleared", 32'(front_out[1]), 32'h0);
    tick();
    check("midstr_stays", 32'(front_out[1]), 32'h0);

    // Async reset mid-stretch
    cfg_write(3'd1, 6'h0C, 1'b0, 8'd5, 1'b1);
    pulses[1] = 1'b1;
    tick();
    pulses[1] = 1'b0;
    tick(); tick();
    check("arst_pre_high", 32'(front_out[1]), 32'h1);
    rst_n = 1'b0;
    #1;
    check("arst_front", 32'(front_out), 32'h0);
    check("arst_pending", 32'(cfg_pending), 32'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("arst_after", 32'(front_out), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
